// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : execute_stage
// Purpose  : Pipelined RISC-V execute stage: ID/EX register, operand forwarding,
//            ALU, branch/jump resolution and EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_e,
  input  logic            flush_e,
  input  logic [2:0]      alu_control_d,
  input  logic            alu_src_d,
  input  logic            reg_write_d,
  input  logic            mem_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            branch_d,
  input  logic            jump_d,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [XLEN-1:0] imm_ext_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic [4:0]      rd_d,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [4:0]      rd_e,
  output logic            load_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] pc_plus4_m
);

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_SLT = 3'b101;
  localparam logic [1:0] c_RES_MEM = 2'b01;

  logic [2:0]      alu_control_e_q, alu_control_e_d;
  logic            alu_src_e_q, alu_src_e_d;
  logic            reg_write_e_q, reg_write_e_d;
  logic            mem_write_e_q, mem_write_e_d;
  logic [1:0]      result_src_e_q, result_src_e_d;
  logic            branch_e_q, branch_e_d;
  logic            jump_e_q, jump_e_d;
  logic [XLEN-1:0] rd1_e_q, rd1_e_d;
  logic [XLEN-1:0] rd2_e_q, rd2_e_d;
  logic [XLEN-1:0] imm_ext_e_q, imm_ext_e_d;
  logic [XLEN-1:0] pc_e_q, pc_e_d;
  logic [4:0]      rs1_e_q, rs1_e_d;
  logic [4:0]      rs2_e_q, rs2_e_d;
  logic [4:0]      rd_e_q, rd_e_d;

  logic            reg_write_m_q;
  logic            mem_write_m_q;
  logic [1:0]      result_src_m_q;
  logic [XLEN-1:0] alu_result_m_q;
  logic [XLEN-1:0] write_data_m_q;
  logic [4:0]      rd_m_q;
  logic [XLEN-1:0] pc_plus4_m_q;

  logic [XLEN-1:0] w_src_a_e;
  logic [XLEN-1:0] w_fwd_b_e;
  logic [XLEN-1:0] w_src_b_e;
  logic [XLEN-1:0] w_alu_result_e;
  logic [XLEN-1:0] w_pc_plus4_e;
  logic            w_zero_e;

  // Flush clears every field so a bubble can never match a forwarding source.
  always_comb begin
    alu_control_e_d = alu_control_e_q;
    alu_src_e_d     = alu_src_e_q;
    reg_write_e_d   = reg_write_e_q;
    mem_write_e_d   = mem_write_e_q;
    result_src_e_d  = result_src_e_q;
    branch_e_d      = branch_e_q;
    jump_e_d        = jump_e_q;
    rd1_e_d         = rd1_e_q;
    rd2_e_d         = rd2_e_q;
    imm_ext_e_d     = imm_ext_e_q;
    pc_e_d          = pc_e_q;
    rs1_e_d         = rs1_e_q;
    rs2_e_d         = rs2_e_q;
    rd_e_d          = rd_e_q;
    if (flush_e) begin
      alu_control_e_d = '0;
      alu_src_e_d     = 1'b0;
      reg_write_e_d   = 1'b0;
      mem_write_e_d   = 1'b0;
      result_src_e_d  = '0;
      branch_e_d      = 1'b0;
      jump_e_d        = 1'b0;
      rd1_e_d         = '0;
      rd2_e_d         = '0;
      imm_ext_e_d     = '0;
      pc_e_d          = '0;
      rs1_e_d         = '0;
      rs2_e_d         = '0;
      rd_e_d          = '0;
    end else if (!stall_e) begin
      alu_control_e_d = alu_control_d;
      alu_src_e_d     = alu_src_d;
      reg_write_e_d   = reg_write_d;
      mem_write_e_d   = mem_write_d;
      result_src_e_d  = result_src_d;
      branch_e_d      = branch_d;
      jump_e_d        = jump_d;
      rd1_e_d         = rd1_d;
      rd2_e_d         = rd2_d;
      imm_ext_e_d     = imm_ext_d;
      pc_e_d          = pc_d;
      rs1_e_d         = rs1_d;
      rs2_e_d         = rs2_d;
      rd_e_d          = rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control_e_q <= '0;
      alu_src_e_q     <= 1'b0;
      reg_write_e_q   <= 1'b0;
      mem_write_e_q   <= 1'b0;
      result_src_e_q  <= '0;
      branch_e_q      <= 1'b0;
      jump_e_q        <= 1'b0;
      rd1_e_q         <= '0;
      rd2_e_q         <= '0;
      imm_ext_e_q     <= '0;
      pc_e_q          <= '0;
      rs1_e_q         <= '0;
      rs2_e_q         <= '0;
      rd_e_q          <= '0;
    end else begin
      alu_control_e_q <= alu_control_e_d;
      alu_src_e_q     <= alu_src_e_d;
      reg_write_e_q   <= reg_write_e_d;
      mem_write_e_q   <= mem_write_e_d;
      result_src_e_q  <= result_src_e_d;
      branch_e_q      <= branch_e_d;
      jump_e_q        <= jump_e_d;
      rd1_e_q         <= rd1_e_d;
      rd2_e_q         <= rd2_e_d;
      imm_ext_e_q     <= imm_ext_e_d;
      pc_e_q          <= pc_e_d;
      rs1_e_q         <= rs1_e_d;
      rs2_e_q         <= rs2_e_d;
      rd_e_q          <= rd_e_d;
    end
  end

  // The M-stage result is younger than W, so it takes priority.
  always_comb begin
    w_src_a_e = rd1_e_q;
    if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == rs1_e_q)) begin
      w_src_a_e = alu_result_m_q;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs1_e_q)) begin
      w_src_a_e = result_w;
    end

    w_fwd_b_e = rd2_e_q;
    if (reg_write_m_q && (rd_m_q != 5'd0) && (rd_m_q == rs2_e_q)) begin
      w_fwd_b_e = alu_result_m_q;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs2_e_q)) begin
      w_fwd_b_e = result_w;
    end
  end

  assign w_src_b_e = alu_src_e_q ? imm_ext_e_q : w_fwd_b_e;

  always_comb begin
    w_alu_result_e = '0;
    case (alu_control_e_q)
      c_ALU_ADD: w_alu_result_e = w_src_a_e + w_src_b_e;
      c_ALU_SUB: w_alu_result_e = w_src_a_e - w_src_b_e;
      c_ALU_AND: w_alu_result_e = w_src_a_e & w_src_b_e;
      c_ALU_OR:  w_alu_result_e = w_src_a_e | w_src_b_e;
      c_ALU_SLT: w_alu_result_e = {{(XLEN-1){1'b0}}, ($signed(w_src_a_e) < $signed(w_src_b_e))};
      default:   w_alu_result_e = '0;
    endcase
  end

  assign w_zero_e     = (w_alu_result_e == '0);
  assign w_pc_plus4_e = pc_e_q + XLEN'(4);
  assign pc_target_e  = pc_e_q + imm_ext_e_q;
  assign pc_src_e     = (branch_e_q & w_zero_e) | jump_e_q;
  assign rd_e         = rd_e_q;
  assign load_e       = (result_src_e_q == c_RES_MEM);

  // EX/MEM ignores stall_e: a held instruction is simply re-issued downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m_q  <= 1'b0;
      mem_write_m_q  <= 1'b0;
      result_src_m_q <= '0;
      alu_result_m_q <= '0;
      write_data_m_q <= '0;
      rd_m_q         <= '0;
      pc_plus4_m_q   <= '0;
    end else begin
      reg_write_m_q  <= reg_write_e_q;
      mem_write_m_q  <= mem_write_e_q;
      result_src_m_q <= result_src_e_q;
      alu_result_m_q <= w_alu_result_e;
      write_data_m_q <= w_fwd_b_e;
      rd_m_q         <= rd_e_q;
      pc_plus4_m_q   <= w_pc_plus4_e;
    end
  end

  assign reg_write_m  = reg_write_m_q;
  assign mem_write_m  = mem_write_m_q;
  assign result_src_m = result_src_m_q;
  assign alu_result_m = alu_result_m_q;
  assign write_data_m = write_data_m_q;
  assign rd_m         = rd_m_q;
  assign pc_plus4_m   = pc_plus4_m_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_stage
// Purpose  : Directed self-checking bench for execute_stage with a reference
//            pipeline model compared every cycle plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst, stall_e, flush_e;
  logic [2:0]  alu_control_d;
  logic        alu_src_d, reg_write_d, mem_write_d, branch_d, jump_d;
  logic [1:0]  result_src_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, result_w;
  logic [4:0]  rs1_d, rs2_d, rd_d, rd_w;
  logic        reg_write_w;
  logic [4:0]  rd_e, rd_m;
  logic        load_e, pc_src_e, reg_write_m, mem_write_m;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [1:0]  result_src_m;

  int checks = 0;
  int passes = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .alu_control_d(alu_control_d), .alu_src_d(alu_src_d),
    .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .result_src_d(result_src_d), .branch_d(branch_d), .jump_d(jump_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .rd_e(rd_e), .load_e(load_e), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .rd_m(rd_m), .pc_plus4_m(pc_plus4_m)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction currently in EX and the M-stage results.
  typedef struct packed {
    bit        rw, mw, br, jp, as;
    bit [1:0]  rsrc;
    bit [2:0]  op;
    bit [31:0] rd1, rd2, imm, pc;
    bit [4:0]  rs1, rs2, rd;
  } instr_t;

  instr_t    m_ex = '0;
  bit        m_rw = 0, m_mw = 0;
  bit [1:0]  m_rsrc = 0;
  bit [31:0] m_alu = 0, m_wd = 0, m_pc4 = 0;
  bit [4:0]  m_rd = 0;
  bit        started = 0;

  function automatic bit [31:0] fwd(input bit [4:0] idx, input bit [31:0] regval);
    if (m_rw && m_rd != 0 && m_rd == idx) return m_alu;
    if (reg_write_w && rd_w != 0 && rd_w == idx) return result_w;
    return regval;
  endfunction

  function automatic bit [31:0] alu_ref(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [31:0] ex_result();
    bit [31:0] b;
    b = m_ex.as ? m_ex.imm : fwd(m_ex.rs2, m_ex.rd2);
    return alu_ref(m_ex.op, fwd(m_ex.rs1, m_ex.rd1), b);
  endfunction

  always @(posedge clk) begin
    bit [31:0] r, wd;
    if (rst) begin
      m_ex = '0; m_rw = 0; m_mw = 0; m_rsrc = 0; m_alu = 0; m_wd = 0; m_rd = 0; m_pc4 = 0;
      started = 1;
    end else begin
      r  = ex_result();
      wd = fwd(m_ex.rs2, m_ex.rd2);
      m_rw = m_ex.rw; m_mw = m_ex.mw; m_rsrc = m_ex.rsrc; m_alu = r; m_wd = wd;
      m_rd = m_ex.rd; m_pc4 = m_ex.pc + 32'd4;
      if (flush_e) m_ex = '0;
      else if (!stall_e) begin
        m_ex.rw = reg_write_d; m_ex.mw = mem_write_d; m_ex.br = branch_d;
        m_ex.jp = jump_d; m_ex.as = alu_src_d; m_ex.rsrc = result_src_d;
        m_ex.op = alu_control_d; m_ex.rd1 = rd1_d; m_ex.rd2 = rd2_d;
        m_ex.imm = imm_ext_d; m_ex.pc = pc_d; m_ex.rs1 = rs1_d;
        m_ex.rs2 = rs2_d; m_ex.rd = rd_d;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    bit [31:0] r;
    if (started) begin
      r = ex_result();
      chk("rd_e", 32'(rd_e), 32'(m_ex.rd));
      chk("load_e", 32'(load_e), 32'(m_ex.rsrc == 2'b01));
      chk("pc_src_e", 32'(pc_src_e), 32'((m_ex.br && r == 0) || m_ex.jp));
      chk("pc_target_e", pc_target_e, m_ex.pc + m_ex.imm);
      chk("reg_write_m", 32'(reg_write_m), 32'(m_rw));
      chk("mem_write_m", 32'(mem_write_m), 32'(m_mw));
      chk("result_src_m", 32'(result_src_m), 32'(m_rsrc));
      chk("alu_result_m", alu_result_m, m_alu);
      chk("write_data_m", write_data_m, m_wd);
      chk("rd_m", 32'(rd_m), 32'(m_rd));
      chk("pc_plus4_m", pc_plus4_m, m_pc4);
    end
  end

  task automatic nop();
    alu_control_d = 0; alu_src_d = 0; reg_write_d = 0; mem_write_d = 0;
    result_src_d = 0; branch_d = 0; jump_d = 0; rd1_d = 0; rd2_d = 0;
    imm_ext_d = 0; pc_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
  endtask

  task automatic op(input bit [2:0] ac, input bit as, input bit rw, input bit [4:0] rs1,
                    input bit [4:0] rs2, input bit [4:0] rd, input bit [31:0] v1,
                    input bit [31:0] v2, input bit [31:0] imm, input bit [31:0] pc);
    nop();
    alu_control_d = ac; alu_src_d = as; reg_write_d = rw; rs1_d = rs1; rs2_d = rs2;
    rd_d = rd; rd1_d = v1; rd2_d = v2; imm_ext_d = imm; pc_d = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; stall_e = 0; flush_e = 0; reg_write_w = 0; rd_w = 0; result_w = 0;
    nop();
    step();
    rst = 0;
    chk("reset alu_result_m", alu_result_m, 32'd0);
    chk("reset reg_write_m", 32'(reg_write_m), 32'd0);
    chk("reset pc_target_e", pc_target_e, 32'd0);

    // add x3 = 5 + 7, then dependents forwarded from M (wins over W) and W
    op(3'd0, 0, 1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0, 32'h10); step();
    chk("add rd_e", 32'(rd_e), 32'd3);
    op(3'd0, 0, 1, 5'd3, 5'd0, 5'd4, 32'd0, 32'd1, 0, 32'h14);
    reg_write_w = 1; rd_w = 5'd3; result_w = 32'd99; step();
    chk("add alu_result_m", alu_result_m, 32'd12);
    chk("add rd_m", 32'(rd_m), 32'd3);
    chk("add reg_write_m", 32'(reg_write_m), 32'd1);
    nop(); step();
    chk("fwd M wins", alu_result_m, 32'd13);
    op(3'd0, 0, 1, 5'd3, 5'd0, 5'd5, 32'd0, 32'd0, 0, 32'h18); step();
    nop(); step();
    chk("fwd from W", alu_result_m, 32'd99);
    reg_write_w = 0; rd_w = 0; result_w = 0;

    // rd_m == 0 must never forward
    op(3'd0, 0, 1, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 0, 0); step();
    op(3'd0, 0, 1, 5'd0, 5'd0, 5'd6, 32'd40, 32'd2, 0, 0); step();
    nop(); step();
    chk("no fwd rd0", alu_result_m, 32'd42);

    // beq taken / not taken
    op(3'd1, 0, 0, 5'd5, 5'd6, 5'd0, 32'd4, 32'd4, 32'h20, 32'h100); branch_d = 1; step();
    chk("beq taken", 32'(pc_src_e), 32'd1);
    chk("beq target", pc_target_e, 32'h120);
    op(3'd1, 0, 0, 5'd5, 5'd6, 5'd0, 32'd4, 32'd5, 32'h20, 32'h100); branch_d = 1; step();
    chk("beq not taken", 32'(pc_src_e), 32'd0);

    // slt overflow case, sub wrap, logic ops with immediate, undefined op
    op(3'd5, 0, 1, 5'd8, 5'd9, 5'd7, 32'h80000000, 32'd1, 0, 0); step();
    op(3'd1, 0, 1, 5'd10, 5'd11, 5'd8, 32'd0, 32'd1, 0, 0); step();
    chk("slt neg", alu_result_m, 32'd1);
    op(3'd2, 1, 1, 5'd14, 5'd15, 5'd10, 32'h0000F0F0, 32'hFFFF, 32'h0FF0, 0); step();
    chk("sub wrap", alu_result_m, 32'hFFFFFFFF);
    op(3'd3, 0, 1, 5'd16, 5'd17, 5'd11, 32'h1200, 32'h34, 0, 0); step();
    chk("and imm", alu_result_m, 32'h000000F0);
    op(3'd4, 0, 1, 5'd18, 5'd19, 5'd12, 32'd3, 32'd3, 0, 0); step();
    chk("or", alu_result_m, 32'h1234);

    // store whose data is forwarded from x12 in M
    op(3'd0, 1, 0, 5'd20, 5'd12, 5'd0, 32'd100, 32'd5, 32'd8, 0); mem_write_d = 1; step();
    chk("undef op", alu_result_m, 32'd0);
    nop(); step();
    chk("store addr", alu_result_m, 32'd108);
    chk("store data fwd", write_data_m, 32'd0);
    chk("store mem_write", 32'(mem_write_m), 32'd1);

    // load flag, then jal
    op(3'd0, 1, 1, 5'd1, 5'd0, 5'd13, 32'd0, 0, 32'd4, 0); result_src_d = 2'b01; step();
    chk("load_e", 32'(load_e), 32'd1);
    op(3'd0, 0, 1, 5'd0, 5'd0, 5'd1, 0, 0, 32'h40, 32'h200); jump_d = 1; result_src_d = 2'b10; step();
    chk("jal redirect", 32'(pc_src_e), 32'd1);
    chk("jal target", pc_target_e, 32'h240);
    nop(); step();
    chk("jal pc_plus4", pc_plus4_m, 32'h204);
    chk("jal result_src", 32'(result_src_m), 32'd2);

    // stall holds ID/EX while EX/MEM keeps re-issuing it
    op(3'd0, 0, 1, 5'd20, 5'd21, 5'd9, 32'd1, 32'd2, 0, 0); step();
    op(3'd0, 0, 1, 5'd22, 5'd23, 5'd15, 32'd100, 32'd100, 0, 0); stall_e = 1; step();
    chk("stall hold rd_e", 32'(rd_e), 32'd9);
    chk("stall reissue", alu_result_m, 32'd3);
    step();
    chk("stall hold 2", 32'(rd_e), 32'd9);
    stall_e = 0; step();
    chk("stall release", 32'(rd_e), 32'd15);

    // stall + flush with jal in decode gives a bubble
    op(3'd0, 0, 1, 5'd0, 5'd0, 5'd1, 0, 0, 32'h40, 32'h300); jump_d = 1;
    stall_e = 1; flush_e = 1; step();
    chk("flush pc_src", 32'(pc_src_e), 32'd0);
    chk("flush rd_e", 32'(rd_e), 32'd0);
    stall_e = 0; flush_e = 0; nop(); step();
    chk("bubble reg_write_m", 32'(reg_write_m), 32'd0);

    // reset mid-stream
    op(3'd0, 0, 1, 5'd1, 5'd2, 5'd2, 32'd1, 32'd1, 32'd4, 32'h400); step();
    op(3'd0, 0, 1, 5'd1, 5'd2, 5'd3, 32'd6, 32'd6, 32'd4, 32'h404); rst = 1; step();
    chk("rst alu_result_m", alu_result_m, 32'd0);
    chk("rst reg_write_m", 32'(reg_write_m), 32'd0);
    chk("rst rd_e", 32'(rd_e), 32'd0);
    chk("rst pc_target_e", pc_target_e, 32'd0);
    rst = 0; nop(); step(); step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall_e  input  1  hold the ID/EX register.
REQ-005 flush_e  input  1  load a bubble into the ID/EX register.
REQ-006 alu_control_d  input  3  ALU operation code from the ALU decoder.
REQ-007 alu_src_d  input  1  SrcB select: 1 = immediate, 0 = rs2 value.
REQ-008 reg_write_d  input  1  instruction writes rd.
REQ-009 mem_write_d  input  1  store instruction.
REQ-010 result_src_d  input  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
REQ-011 branch_d  input  1  conditional branch (beq).
REQ-012 jump_d  input  1  unconditional jump (jal).
REQ-013 rd1_d  input  XLEN  register-file rs1 value.
REQ-014 rd2_d  input  XLEN  register-file rs2 value.
REQ-015 imm_ext_d  input  XLEN  sign-extended immediate.
REQ-016 pc_d  input  XLEN  instruction PC.
REQ-017 rs1_d  input  5  source register 1 index.
REQ-018 rs2_d  input  5  source register 2 index.
REQ-019 rd_d  input  5  destination register index.
REQ-020 reg_write_w  input  1  writeback stage writes rd_w.
REQ-021 rd_w  input  5  writeback destination index.
REQ-022 result_w  input  XLEN  writeback result value.
REQ-023 rd_e  output  5  EX-stage rd, for load-use hazard detection.
REQ-024 load_e  output  1  EX instruction is a load (result_src_e == 01).
REQ-025 pc_src_e  output  1  redirect fetch to pc_target_e.
REQ-026 pc_target_e  output  XLEN  branch/jump target, pc_e + imm_ext_e.
REQ-027 reg_write_m  output  1  EX/MEM registered reg_write.
REQ-028 mem_write_m  output  1  EX/MEM registered mem_write.
REQ-029 result_src_m  output  2  EX/MEM registered result_src.
REQ-030 alu_result_m  output  XLEN  EX/MEM registered ALU result.
REQ-031 write_data_m  output  XLEN  EX/MEM registered store data (forwarded rs2).
REQ-032 rd_m  output  5  EX/MEM registered rd.
REQ-033 pc_plus4_m  output  XLEN  EX/MEM registered pc_e + 4.

Function
REQ-034 ID/EX register priority: rst, then flush_e (all fields cleared), then stall_e (hold), else capture the *_d inputs; flush_e wins over a simultaneous stall_e.
REQ-035 Forward operand A: alu_result_m if reg_write_m, rd_m != 0, and rd_m == rs1_e; else result_w if reg_write_w, rd_w != 0, and rd_w == rs1_e; else rd1_e. The M-stage source has priority over the W-stage source.
REQ-036 Forward operand B uses the same rule on rs2_e/rd2_e; write data is the forwarded B value, and SrcB = alu_src_e ? imm_ext_e : forwarded B.
REQ-037 ALU encoding: 000 add; 001 sub; 010 and; 011 or; 101 signed slt (result 1 or 0, overflow-correct); every other code produces 0. Add and sub wrap modulo 2^32.
REQ-038 zero_e = (ALU result == 0); pc_src_e = (branch_e AND zero_e) OR jump_e, combinational in the same cycle.
REQ-039 pc_target_e = pc_e + imm_ext_e and pc_plus4 = pc_e + 4; both wrap modulo 2^32 and are combinational.
REQ-040 The EX/MEM register captures every cycle; stall_e does not freeze it. While stall_e holds ID/EX, the held instruction is re-issued to EX/MEM every cycle, and the hazard unit pairs stall_e with flush_e for a load-use bubble.
REQ-041 Bubble: all control bits 0 and rd 0, so a bubble produces no writes, no redirect, and no forwarding match.

Reset
REQ-042 When rst is high at a clock edge, all ID/EX and EX/MEM fields SHALL become 0; every registered output then reads 0, and pc_src_e = 0, pc_target_e = 0, load_e = 0.

Verification
REQ-043 add x3, rd1=5, rd2=7, no hazards -> one cycle later alu_result_m=12, rd_m=3, reg_write_m=1.
REQ-044 Back-to-back dependence: rd_m=3 with result 12 and reg_write_m=1, next instruction rs1=3, rd1_d=0, and W also targets x3 with value 99 -> A uses 12 (M wins); when rd_m=0 instead -> no forward.
REQ-045 beq with equal operands 4,4, pc_d=0x100, imm=0x20 -> pc_src_e=1, pc_target_e=0x120; with operands 4,5 -> pc_src_e=0.
REQ-046 slt with 0x80000000 vs 1 -> result 1; sub 0 - 1 -> 0xFFFFFFFF.
REQ-047 Stall and flush asserted together while a jal is in decode -> ID/EX holds a bubble, pc_src_e=0, next reg_write_m=0; rst asserted mid-stream -> all outputs 0 at the next edge.
